// File: rtl/wide_add_sequencer.sv
// Wide adder built from one BIT_WIDTH ripple adder, one word per cycle.
// WIDE_ADD_SIGNED_OVF_EN: overflow reports signed overflow instead of carry.
module adder_nbit #(
  parameter int BIT_WIDTH = 4
) (
  input  logic [BIT_WIDTH-1:0] a,
  input  logic [BIT_WIDTH-1:0] b,
  input  logic                 carry_in,
  output logic [BIT_WIDTH-1:0] sum,
  output logic                 carry_out
);
  logic [BIT_WIDTH:0] c;

  always_comb begin
    c = '0;
    sum = '0;
    c[0] = carry_in;
    for (int i = 0; i < BIT_WIDTH; i++) begin
      sum[i] = a[i] ^ b[i] ^ c[i];
      c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
    carry_out = c[BIT_WIDTH];
  end
endmodule

module wide_add_sequencer #(
  parameter int BIT_WIDTH = 4,
  parameter int NUM_WORDS = 4
) (
  input  logic                           clk,
  input  logic                           n_rst,
  input  logic                           start,
  input  logic [BIT_WIDTH*NUM_WORDS-1:0] op_a,
  input  logic [BIT_WIDTH*NUM_WORDS-1:0] op_b,
  input  logic                           carry_in,
  output logic                           busy,
  output logic                           done,
  output logic [BIT_WIDTH*NUM_WORDS-1:0] sum,
  output logic                           overflow
);
  localparam int W = BIT_WIDTH * NUM_WORDS;
  localparam int IW = (NUM_WORDS > 2) ? $clog2(NUM_WORDS) : 1;
  localparam logic [IW-1:0] LAST = IW'(NUM_WORDS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [W-1:0]   a_q, a_d;
  logic [W-1:0]   b_q, b_d;
  logic [W-1:0]   part_q, part_d;
  logic [W-1:0]   sum_q, sum_d;
  logic [IW-1:0]  idx_q, idx_d;
  logic           carry_q, carry_d;
  logic           ovf_q, ovf_d;

  logic [BIT_WIDTH-1:0] add_a, add_b, add_s;
  logic                 add_co;

  assign add_a = a_q[int'(idx_q)*BIT_WIDTH +: BIT_WIDTH];
  assign add_b = b_q[int'(idx_q)*BIT_WIDTH +: BIT_WIDTH];

  adder_nbit #(.BIT_WIDTH(BIT_WIDTH)) u_add (
    .a        (add_a),
    .b        (add_b),
    .carry_in (carry_q),
    .sum      (add_s),
    .carry_out(add_co)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    part_d  = part_q;
    sum_d   = sum_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = op_a;
          b_d     = op_b;
          carry_d = carry_in;
          idx_d   = '0;
          state_d = ADD;
        end
      end
      ADD: begin
        part_d[int'(idx_q)*BIT_WIDTH +: BIT_WIDTH] = add_s;
        carry_d = add_co;
        idx_d   = idx_q + 1'b1;
        if (idx_q == LAST) begin
          idx_d   = '0;
          sum_d   = part_d;
          state_d = DONE;
`ifdef WIDE_ADD_SIGNED_OVF_EN
          ovf_d = (a_q[W-1] == b_q[W-1]) &&
                  (add_s[BIT_WIDTH-1] != a_q[W-1]);
`else
          ovf_d = add_co;
`endif
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      part_q  <= '0;
      sum_q   <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      part_q  <= part_d;
      sum_q   <= sum_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy     = (state_q == ADD);
  assign done     = (state_q == DONE);
  assign sum      = sum_q;
  assign overflow = ovf_q;
endmodule
